fclassify_pipe: RTL and testbench

- Parametrised, pipelined FP classify unit for FCLASS on all configured formats (H/S/D/Q).
- Extracts sign, exponent and fraction from a packed FLEN-bit operand, checks NaN-boxing, and produces the 10-bit RISC-V class mask zero-extended to XLEN.
- Result is held in a single valid/ready output register with backpressure and flush.
- Sits between the FPU operand mux and the integer writeback path.

---
 rtl/fclassify_pipe.sv | 117 +++++++++++
 tb/tb_fclassify_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fclassify_pipe.sv
// Pipelined FCLASS unit: one-cycle classify of an H/S/D/Q operand into a held valid/ready result.
// Optional per-class saturating event counters are built when FCLASS_COUNT_EN is defined.
module fclassify_pipe #(
    parameter int XLEN = 64,
    parameter int FLEN = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FLEN-1:0] X,
    input  logic [1:0]      Fmt,
    input  logic            InValid,
    output logic            InReady,
    input  logic            Flush,
    output logic [XLEN-1:0] ClassRes,
    output logic            FmtErr,
    output logic            OutValid,
    input  logic            OutReady,
    input  logic [3:0]      CntSel,
    input  logic            CntClr,
    output logic [CNTW-1:0] CntVal
);

    logic [127:0] xw;
    int           fw;
    logic         sgn, exp_ones, exp_zero, frac_zero, frac_msb, box_ok;
    logic [9:0]   cls_n, cls_q;
    logic         err_n, cap;

    // Operand is zero-extended to the widest format so every field slice stays in range.
    always_comb begin
        xw = '0;
        xw[FLEN-1:0] = X;
        fw = 32; sgn = 1'b0; exp_ones = 1'b0; exp_zero = 1'b0; frac_zero = 1'b0; frac_msb = 1'b0;
        case (Fmt)
            2'b00: begin
                fw = 32; sgn = xw[31];
                exp_ones = &xw[30:23]; exp_zero = ~|xw[30:23];
                frac_zero = ~|xw[22:0]; frac_msb = xw[22];
            end
            2'b01: begin
                fw = 64; sgn = xw[63];
                exp_ones = &xw[62:52]; exp_zero = ~|xw[62:52];
                frac_zero = ~|xw[51:0]; frac_msb = xw[51];
            end
            2'b10: begin
                fw = 16; sgn = xw[15];
                exp_ones = &xw[14:10]; exp_zero = ~|xw[14:10];
                frac_zero = ~|xw[9:0]; frac_msb = xw[9];
            end
            default: begin
                fw = 128; sgn = xw[127];
                exp_ones = &xw[126:112]; exp_zero = ~|xw[126:112];
                frac_zero = ~|xw[111:0]; frac_msb = xw[111];
            end
        endcase

        box_ok = 1'b1;
        for (int i = 0; i < FLEN; i++)
            if (i >= fw && !X[i]) box_ok = 1'b0;

        err_n = (fw > FLEN);
        cls_n = '0;
        if (err_n)                     cls_n = '0;
        else if (!box_ok)              cls_n[9] = 1'b1;
        else if (exp_ones && frac_zero) cls_n[sgn ? 0 : 7] = 1'b1;
        else if (exp_ones)             cls_n[frac_msb ? 9 : 8] = 1'b1;
        else if (exp_zero && frac_zero) cls_n[sgn ? 3 : 4] = 1'b1;
        else if (exp_zero)             cls_n[sgn ? 2 : 5] = 1'b1;
        else                           cls_n[sgn ? 1 : 6] = 1'b1;
    end

    assign InReady = ~OutValid | OutReady;
    assign cap     = InValid & InReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            OutValid <= 1'b0;
            cls_q    <= '0;
            FmtErr   <= 1'b0;
        end else begin
            if (cap) begin
                cls_q  <= cls_n;
                FmtErr <= err_n;
            end
            if (Flush)                OutValid <= 1'b0;
            else if (cap)             OutValid <= 1'b1;
            else if (OutReady)        OutValid <= 1'b0;
        end
    end

    always_comb begin
        ClassRes = '0;
        ClassRes[9:0] = cls_q;
    end

`ifdef FCLASS_COUNT_EN
    logic [9:0][CNTW-1:0] cnt;

    // A flushed capture still counts; unsupported formats have an empty mask and never count.
    for (genvar g = 0; g < 10; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset || CntClr)
                cnt[g] <= '0;
            else if (cap && cls_n[g] && !(&cnt[g]))
                cnt[g] <= cnt[g] + 1'b1;
        end
    end

    assign CntVal = (CntSel < 4'd10) ? cnt[CntSel] : '0;
`else
    logic unused_cnt;
    assign unused_cnt = ^{CntSel, CntClr};
    assign CntVal     = '0;
`endif

endmodule

// File: tb/tb_fclassify_pipe.sv
// Directed bench for fclassify_pipe: vector table plus backpressure, flush, reset and counter sequences.
module tb_fclassify_pipe;
`ifdef FCLASS_COUNT_EN
    localparam int CNTW = 2;
`else
    localparam int CNTW = 16;
`endif
    localparam int XLEN = 64;
    localparam int FLEN = 64;

    logic            clk = 1'b0;
    logic            reset, InValid, InReady, Flush, FmtErr, OutValid, OutReady, CntClr;
    logic [FLEN-1:0] X;
    logic [1:0]      Fmt;
    logic [XLEN-1:0] ClassRes;
    logic [3:0]      CntSel;
    logic [CNTW-1:0] CntVal;

    int checks = 0;
    int errors = 0;

    fclassify_pipe #(.XLEN(XLEN), .FLEN(FLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .X(X), .Fmt(Fmt), .InValid(InValid), .InReady(InReady),
        .Flush(Flush), .ClassRes(ClassRes), .FmtErr(FmtErr), .OutValid(OutValid),
        .OutReady(OutReady), .CntSel(CntSel), .CntClr(CntClr), .CntVal(CntVal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [1:0]  fmt;
        logic [9:0]  cls;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{64'hFFFFFFFF3F800000, 2'b00, 10'h040, 1'b0};
        vecs[1]  = '{64'h000000003F800000, 2'b00, 10'h200, 1'b0};
        vecs[2]  = '{64'h8000000000000000, 2'b01, 10'h008, 1'b0};
        vecs[3]  = '{64'h0000000000000001, 2'b01, 10'h020, 1'b0};
        vecs[4]  = '{64'hFFFFFFFFFFFF7C01, 2'b10, 10'h100, 1'b0};
        vecs[5]  = '{64'hFFFFFFFFFFFFFC00, 2'b10, 10'h001, 1'b0};
        vecs[6]  = '{64'hFFFFFFFF7FC00000, 2'b00, 10'h200, 1'b0};
        vecs[7]  = '{64'hFFFFFFFF80000001, 2'b00, 10'h004, 1'b0};
        vecs[8]  = '{64'hBFF0000000000000, 2'b01, 10'h002, 1'b0};
        vecs[9]  = '{64'h7FF0000000000000, 2'b01, 10'h080, 1'b0};
        vecs[10] = '{64'hFFFFFFFFFFFF0000, 2'b10, 10'h010, 1'b0};
        vecs[11] = '{64'h0000FFFFFFFF3C00, 2'b10, 10'h200, 1'b0};
        vecs[12] = '{64'h7FF8000000000000, 2'b01, 10'h200, 1'b0};
        vecs[13] = '{64'hFFFFFFFF3F800000, 2'b11, 10'h000, 1'b1};

        reset = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1; CntClr = 1'b0;
        CntSel = 4'd0; X = '0; Fmt = 2'b00;
        step(); step();
        chk("reset_outvalid", 64'(OutValid), 64'd0);
        chk("reset_classres", ClassRes, 64'd0);
        chk("reset_fmterr", 64'(FmtErr), 64'd0);
        chk("reset_inready", 64'(InReady), 64'd1);
        reset = 1'b0;

        // Back-to-back captures with OutReady high: one result per cycle.
        for (int i = 0; i < 14; i++) begin
            X = vecs[i].x; Fmt = vecs[i].fmt; InValid = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(OutValid), 64'd1);
            chk($sformatf("vec%0d_class", i), ClassRes, {54'd0, vecs[i].cls});
            chk($sformatf("vec%0d_fmterr", i), 64'(FmtErr), 64'(vecs[i].err));
        end
        InValid = 1'b0;
        step();
        chk("drain_outvalid", 64'(OutValid), 64'd0);

        // Backpressure: first result held, second operand waits.
        X = 64'hBFF0000000000000; Fmt = 2'b01; InValid = 1'b1; OutReady = 1'b0;
        step();
        chk("bp_first_valid", 64'(OutValid), 64'd1);
        chk("bp_first_class", ClassRes, 64'h002);
        X = 64'h7FF0000000000000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("bp_hold%0d_class", c), ClassRes, 64'h002);
            chk($sformatf("bp_hold%0d_inready", c), 64'(InReady), 64'd0);
            chk($sformatf("bp_hold%0d_valid", c), 64'(OutValid), 64'd1);
        end
        OutReady = 1'b1;
        #1;
        chk("bp_inready_up", 64'(InReady), 64'd1);
        step();
        chk("bp_second_valid", 64'(OutValid), 64'd1);
        chk("bp_second_class", ClassRes, 64'h080);
        InValid = 1'b0;
        step();
        chk("bp_no_dup", 64'(OutValid), 64'd0);

        // Flush overrides a same-cycle capture.
        X = 64'hFFFFFFFF3F800000; Fmt = 2'b00; InValid = 1'b1; Flush = 1'b1;
        step();
        chk("flush_capture", 64'(OutValid), 64'd0);
        Flush = 1'b0; OutReady = 1'b0;
        step();
        chk("pre_reset_valid", 64'(OutValid), 64'd1);
        InValid = 1'b0; reset = 1'b1;
        step();
        chk("reset_clears_valid", 64'(OutValid), 64'd0);
        chk("reset_clears_class", ClassRes, 64'd0);
        reset = 1'b0; OutReady = 1'b1;

`ifdef FCLASS_COUNT_EN
        CntClr = 1'b1;
        step();
        CntClr = 1'b0;
        X = 64'hFFFFFFFF3F800000; Fmt = 2'b00; InValid = 1'b1;
        for (int k = 0; k < 5; k++) step();
        InValid = 1'b0;
        CntSel = 4'd6; #1;
        chk("cnt_norm_sat", 64'(CntVal), 64'd3);
        CntSel = 4'd4; #1;
        chk("cnt_pzero", 64'(CntVal), 64'd0);
        CntSel = 4'd12; #1;
        chk("cnt_sel_oob", 64'(CntVal), 64'd0);
        X = 64'h8000000000000000; Fmt = 2'b01; InValid = 1'b1;
        step();
        InValid = 1'b0;
        CntSel = 4'd3; #1;
        chk("cnt_nzero", 64'(CntVal), 64'd1);
        X = 64'hFFFFFFFF3F800000; Fmt = 2'b11; InValid = 1'b1;
        step();
        InValid = 1'b0;
        CntSel = 4'd9; #1;
        chk("cnt_fmterr_none", 64'(CntVal), 64'd0);
        X = 64'hFFFFFFFF3F800000; Fmt = 2'b00; InValid = 1'b1; CntClr = 1'b1;
        step();
        InValid = 1'b0; CntClr = 1'b0;
        CntSel = 4'd6; #1;
        chk("cnt_clr_norm", 64'(CntVal), 64'd0);
        CntSel = 4'd3; #1;
        chk("cnt_clr_nzero", 64'(CntVal), 64'd0);
`else
        CntSel = 4'd6; #1;
        chk("cntval_tied", 64'(CntVal), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
